tlp_tx_framer: RTL and testbench

Transmit-side framer in the transaction layer. Accepts a memory request descriptor plus an optional payload stream and serializes a 3DW PCIe TLP header followed by payload DWs into the TX FIFO. It sits directly upstream of the FIFO write pointer: it drives the FIFO write strobe and data, and obeys the FIFO full flag as backpressure. It produces at most one DW per cycle.

---
 rtl/tlp_tx_framer.sv | 132 +++++++++++++
 tb/tb_tlp_tx_framer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tlp_tx_framer.sv
// Serializes a 3DW MRd/MWr TLP header plus payload DWs into the TX FIFO, one DW per cycle; first header write the cycle after capture.
// Backpressure: fifo_full freezes state, counter and word; payload is consumed only when pl_ready & pl_valid.
module tlp_tx_framer #(
  parameter logic [15:0] REQ_ID = 16'h0100,
  parameter int          LEN_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [31:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       req_tag,
  input  logic             pl_valid,
  output logic             pl_ready,
  input  logic [31:0]      pl_data,
  input  logic             fifo_full,
  output logic             wr,
  output logic [33:0]      wdata,
  output logic             pkt_done
);

  localparam int CNT_W = LEN_W + 1;

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, PAYLOAD} state_t;

  state_t             state_q, state_d;
  logic               is_wr_q, is_wr_d;
  logic [31:0]        addr_q, addr_d;
  logic [7:0]         tag_q, tag_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [CNT_W-1:0]   len_eff;
  logic [31:0]        dw0, dw1, dw2, dw;
  logic               sof, eof;

  // A zero length field encodes the maximum, 2^LEN_W DW.
  assign len_eff = (req_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, req_len};

  always_comb begin
    dw0        = '0;
    dw0[31:29] = is_wr_q ? 3'b010 : 3'b000;
    dw0[9:0]   = 10'(len_q);
  end

  assign dw1 = {REQ_ID, tag_q, (len_q == CNT_W'(1)) ? 4'h0 : 4'hF, 4'hF};
  assign dw2 = addr_q;

  always_comb begin
    req_ready = 1'b0;
    pl_ready  = 1'b0;
    wr        = 1'b0;
    sof       = 1'b0;
    eof       = 1'b0;
    dw        = '0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      HDR0: begin
        wr  = ~fifo_full;
        sof = 1'b1;
        dw  = dw0;
      end
      HDR1: begin
        wr = ~fifo_full;
        dw = dw1;
      end
      HDR2: begin
        wr  = ~fifo_full;
        eof = ~is_wr_q;
        dw  = dw2;
      end
      PAYLOAD: begin
        pl_ready = ~fifo_full;
        wr       = pl_valid & ~fifo_full;
        eof      = (cnt_q == CNT_W'(1));
        dw       = pl_data;
      end
      default: ;
    endcase
  end

  assign wdata    = {sof, eof, dw};
  assign pkt_done = wr & eof;

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    tag_d   = tag_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = HDR0;
        is_wr_d = req_wr;
        addr_d  = req_addr & 32'hFFFF_FFFC;
        tag_d   = req_tag;
        len_d   = len_eff;
        cnt_d   = len_eff;
      end
      HDR0: if (!fifo_full) state_d = HDR1;
      HDR1: if (!fifo_full) state_d = HDR2;
      HDR2: if (!fifo_full) state_d = is_wr_q ? PAYLOAD : IDLE;
      PAYLOAD: if (wr) begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      tag_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_tlp_tx_framer.sv
// Bench for tlp_tx_framer: directed and randomized packets checked against a word-list model of the TLP format.
module tb_tlp_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_len = '0;
  logic [7:0]  req_tag = '0;
  logic        pl_valid = 1'b0;
  logic [31:0] pl_data = '0;
  logic        fifo_full = 1'b0;
  logic        req_ready, pl_ready, wr, pkt_done;
  logic [33:0] wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [33:0] obs_q[$];
  logic [33:0] exp_q[$];
  logic [31:0] pl_mem[16];

  always #5 clk = ~clk;

  tlp_tx_framer #(.REQ_ID(16'h0100), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len), .req_tag(req_tag),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .fifo_full(fifo_full), .wr(wr), .wdata(wdata), .pkt_done(pkt_done)
  );

  always @(negedge clk) begin
    if (wr) obs_q.push_back(wdata);
    if (pkt_done) done_cnt++;
  end

  // Expected FIFO words for one packet, straight from the TLP field layout.
  function automatic void model_pkt(input logic w, input logic [31:0] a, input logic [3:0] l, input logic [7:0] t);
    int n;
    logic [31:0] d0, d1, d2;
    n  = (l == 4'd0) ? 16 : int'(l);
    d0 = (w ? 32'h4000_0000 : 32'h0) + 32'(n);
    d1 = {16'h0100, t, (n == 1) ? 4'h0 : 4'hF, 4'hF};
    d2 = {a[31:2], 2'b00};
    exp_q.push_back({2'b10, d0});
    exp_q.push_back({2'b00, d1});
    exp_q.push_back({1'b0, ~w, d2});
    if (w) for (int i = 0; i < n; i++) exp_q.push_back({1'b0, (i == n - 1), pl_mem[i]});
  endfunction

  // stall_mode: 0 none, 1 random, 2 three cycles at HDR1 and two after the first payload DW.
  // gap_mode: 0 pl_valid always, 1 every other cycle, 2 random.
  task automatic drive_pkt(input logic w, input logic [31:0] a, input logic [3:0] l, input logic [7:0] t,
                           input int stall_mode, input int gap_mode, output int cyc, output int stall_wr);
    int n, idx, nwr, stl;
    bit done, s1, s2;
    n = (l == 4'd0) ? 16 : int'(l);
    idx = 0; nwr = 0; stl = 0; done = 0; s1 = 0; s2 = 0; cyc = 0; stall_wr = 0;
    req_valid = 1'b1; req_wr = w; req_addr = a; req_len = l; req_tag = t;
    fifo_full = 1'b0; pl_valid = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom;
    while (!done && cyc < 400) begin
      if (stall_mode == 2 && nwr == 1 && !s1) begin stl = 3; s1 = 1; end
      if (stall_mode == 2 && nwr == 4 && !s2) begin stl = 2; s2 = 1; end
      if (stall_mode == 1) fifo_full = ($urandom_range(0, 2) == 0);
      else begin
        fifo_full = (stl > 0);
        if (stl > 0) stl--;
      end
      pl_valid = (idx < n) && (gap_mode == 0 || (gap_mode == 1 && cyc % 2 == 1) ||
                               (gap_mode == 2 && $urandom_range(0, 1) == 1));
      pl_data = (idx < n) ? pl_mem[idx] : $urandom;
      @(negedge clk);
      if (wr) nwr++;
      if (fifo_full && wr) stall_wr++;
      if (pl_valid && pl_ready) idx++;
      if (pkt_done) done = 1;
      @(posedge clk); #1;
      cyc++;
    end
    fifo_full = 1'b0;
    pl_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (wr !== 1'b0) begin n_bad++; $display("FAIL reset_wr: got %b want 0", wr); end
    n_cmp++; if (wdata !== 34'h0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", wdata); end
    n_cmp++; if (pl_ready !== 1'b0) begin n_bad++; $display("FAIL reset_pl_ready: got %b want 0", pl_ready); end
    n_cmp++; if (pkt_done !== 1'b0) begin n_bad++; $display("FAIL reset_pkt_done: got %b want 0", pkt_done); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mrd_basic();
    logic [33:0] lit[3];
    int cyc, sw, d0;
    lit[0] = 34'h2_0000_0001; lit[1] = 34'h0_0100_050F; lit[2] = 34'h1_1000_0004;
    obs_q.delete(); d0 = done_cnt;
    drive_pkt(1'b0, 32'h1000_0007, 4'd1, 8'h05, 0, 0, cyc, sw);
    n_cmp++; if (cyc !== 3) begin n_bad++; $display("FAIL mrd_cycles: got %0d want 3", cyc); end
    n_cmp++; if (obs_q.size() !== 3) begin n_bad++; $display("FAIL mrd_words: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== lit[i]) begin n_bad++; $display("FAIL mrd_word%0d: got %h want %h", i, obs_q[i], lit[i]); end
    end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL mrd_pkt_done: got %0d pulses want 1", done_cnt - d0); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mrd_req_ready_after: got %b want 1", req_ready); end
  endtask

  task automatic test_mwr(input int stall_mode, input int want_cyc);
    logic [33:0] lit[5];
    int cyc, sw, d0;
    lit[0] = 34'h2_4000_0002; lit[1] = 34'h0_0100_0AFF; lit[2] = 34'h0_2000_0010;
    lit[3] = 34'h0_AAAA_0001; lit[4] = 34'h1_AAAA_0002;
    pl_mem[0] = 32'hAAAA_0001; pl_mem[1] = 32'hAAAA_0002;
    obs_q.delete(); d0 = done_cnt;
    drive_pkt(1'b1, 32'h2000_0010, 4'd2, 8'h0A, stall_mode, 0, cyc, sw);
    n_cmp++; if (cyc !== want_cyc) begin n_bad++; $display("FAIL mwr%0d_cycles: got %0d want %0d", stall_mode, cyc, want_cyc); end
    n_cmp++; if (sw !== 0) begin n_bad++; $display("FAIL mwr%0d_wr_while_full: got %0d want 0", stall_mode, sw); end
    n_cmp++; if (obs_q.size() !== 5) begin n_bad++; $display("FAIL mwr%0d_words: got %0d want 5", stall_mode, obs_q.size()); end
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== lit[i]) begin n_bad++; $display("FAIL mwr%0d_word%0d: got %h want %h", stall_mode, i, obs_q[i], lit[i]); end
    end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL mwr%0d_pkt_done: got %0d want 1", stall_mode, done_cnt - d0); end
  endtask

  task automatic test_len_max();
    int cyc, sw;
    for (int i = 0; i < 16; i++) pl_mem[i] = $urandom;
    obs_q.delete(); exp_q.delete();
    model_pkt(1'b1, 32'h3000_0100, 4'd0, 8'h33);
    drive_pkt(1'b1, 32'h3000_0100, 4'd0, 8'h33, 0, 0, cyc, sw);
    n_cmp++; if (cyc !== 19) begin n_bad++; $display("FAIL lenmax_cycles: got %0d want 19", cyc); end
    n_cmp++; if (obs_q.size() > 0 && obs_q[0] !== 34'h2_4000_0010) begin n_bad++; $display("FAIL lenmax_dw0: got %h want 240000010", obs_q[0]); end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL lenmax_words: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL lenmax_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (pl_ready !== 1'b0) begin n_bad++; $display("FAIL lenmax_pl_ready_after: got %b want 0", pl_ready); end
  endtask

  task automatic test_gaps();
    int cyc, sw, d0;
    for (int i = 0; i < 4; i++) pl_mem[i] = $urandom;
    obs_q.delete(); exp_q.delete(); d0 = done_cnt;
    model_pkt(1'b1, 32'h4000_0008, 4'd4, 8'h44);
    drive_pkt(1'b1, 32'h4000_0008, 4'd4, 8'h44, 0, 1, cyc, sw);
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL gaps_words: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL gaps_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL gaps_pkt_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int cyc, sw, d0, neof;
    for (int i = 0; i < 4; i++) pl_mem[i] = $urandom;
    obs_q.delete(); d0 = done_cnt;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h5000_0000; req_len = 4'd4; req_tag = 8'h55;
    @(posedge clk); #1;
    req_valid = 1'b0; pl_valid = 1'b1; pl_data = pl_mem[0];
    repeat (4) begin @(posedge clk); #1; end
    pl_data = pl_mem[1];
    n_cmp++; if (pl_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_payload: pl_ready got %b want 1", pl_ready); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (wr !== 1'b0) begin n_bad++; $display("FAIL rstmid_wr: got %b want 0", wr); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_req_ready: got %b want 1", req_ready); end
    n_cmp++; if (pl_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_pl_ready: got %b want 0", pl_ready); end
    neof = 0;
    foreach (obs_q[i]) if (obs_q[i][32]) neof++;
    n_cmp++; if (obs_q.size() !== 4 || neof !== 0) begin n_bad++; $display("FAIL rstmid_partial: got %0d words %0d eof want 4 words 0 eof", obs_q.size(), neof); end
    pl_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt - d0); end
    obs_q.delete(); exp_q.delete();
    model_pkt(1'b0, 32'h6000_0ABC, 4'd3, 8'h66);
    drive_pkt(1'b0, 32'h6000_0ABC, 4'd3, 8'h66, 0, 0, cyc, sw);
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rstmid_new_words: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rstmid_new_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, sw, d0, n_pkt, sw_tot, late, rr_bad;
    logic w;
    logic [31:0] a;
    logic [3:0] l;
    logic [7:0] t;
    obs_q.delete(); exp_q.delete(); d0 = done_cnt;
    n_pkt = 12; sw_tot = 0; late = 0; rr_bad = 0;
    for (int p = 0; p < n_pkt; p++) begin
      w = 1'($urandom_range(0, 1)); a = $urandom; l = 4'($urandom_range(0, 15)); t = 8'($urandom);
      for (int i = 0; i < 16; i++) pl_mem[i] = $urandom;
      model_pkt(w, a, l, t);
      drive_pkt(w, a, l, t, 1, 2, cyc, sw);
      sw_tot += sw;
      if (cyc >= 400) late++;
      if (req_ready !== 1'b1) rr_bad++;
    end
    n_cmp++; if (late !== 0) begin n_bad++; $display("FAIL b2b_timeout: got %0d packets unfinished want 0", late); end
    n_cmp++; if (rr_bad !== 0) begin n_bad++; $display("FAIL b2b_req_ready: got %0d not-ready after done want 0", rr_bad); end
    n_cmp++; if (sw_tot !== 0) begin n_bad++; $display("FAIL b2b_wr_while_full: got %0d want 0", sw_tot); end
    n_cmp++; if (done_cnt - d0 !== n_pkt) begin n_bad++; $display("FAIL b2b_pkt_done: got %0d want %0d", done_cnt - d0, n_pkt); end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL b2b_words: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mrd_basic();
    test_mwr(0, 5);
    test_mwr(2, 10);
    test_len_max();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
